mem_port_arbiter: RTL

Arbitrates one single-port unified instruction/data memory between the fetch stage and the MEM stage of the pipelined RISC-V core. Each grant becomes exactly one memory transaction, held stable until the memory completes it. The read data or write acknowledge then returns to the winning requester. Data accesses have priority over fetch, and a streak limit bounds how long fetch can be starved.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared bus bundle between fetch, MEM stage, arbiter and the unified memory.
// The slave view is the arbiter; the master view is everything around it.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data has priority over fetch,
// with a streak limit so fetch is never starved indefinitely.
module mem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2
  } state_e;

  state_e            state_q;
  logic [SW-1:0]     streak_q, streak_d;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic idle, pick_d, if_gnt, d_gnt;

  assign idle   = (state_q == IDLE);
  // Fetch wins a collision only once data has used up its streak.
  assign pick_d = bus.d_req &&
                  !(bus.if_req && streak_q == SMAX);
  assign d_gnt  = idle && pick_d;
  assign if_gnt = idle && bus.if_req && !pick_d;

  always_comb begin
    streak_d = streak_q;
    if (d_gnt) begin
      if (!bus.if_req)
        streak_d = '0;
      else if (streak_q != SMAX)
        streak_d = streak_q + SW'(1);
    end else if (if_gnt) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      streak_q    <= streak_d;
      unique case (state_q)
        IDLE: begin
          if (d_gnt) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            state_q     <= WAIT_D;
          end else if (if_gnt) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.if_addr;
            state_q    <= WAIT_IF;
          end
        end
        WAIT_IF: begin
          if (bus.mem_ack) begin
            if_rdata_q  <= bus.mem_rdata;
            if_rvalid_q <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        WAIT_D: begin
          if (bus.mem_ack) begin
            if (!mem_we_q)
              d_rdata_q <= bus.mem_rdata;
            d_rvalid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = !idle;

endmodule
